hamming_stream_tx: RTL and testbench

- Transmit-side companion to the serial Hamming-distance accumulator, which consumes one input bit per clock cycle for N cycles.
- Accepts an N-bit operand as N/W chunks of W bits over a valid/ready handshake.
- Streams the operand LSB-first, one bit per cycle, with frame markers, so the accumulator sees an uninterrupted N-cycle bitstream.
- Double-buffered (shift register plus holding register) so a steady chunk supply gives a gap-free stream.

---
 rtl/hamming_stream_tx_pkg.sv | 16 +
 rtl/hamming_chunk_buffer.sv | 60 ++++++
 rtl/hamming_stream_tx.sv | 125 ++++++++++++
 tb/tb_hamming_stream_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_stream_tx_pkg.sv
// Shared types and elaboration helpers for the Hamming bitstream transmitter.
package hamming_stream_tx_pkg;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} tx_state_e;

  localparam int DEFAULT_N  = 1600;
  localparam int DEFAULT_W  = 32;
  localparam int DEFAULT_CW = 11;
  localparam int CHUNKS     = DEFAULT_N / DEFAULT_W;
  localparam int CHW        = $clog2(CHUNKS + 1);

  function automatic bit params_ok(input int n, input int w, input int cw);
    return (w > 0) && (n % w == 0) && (cw >= $clog2(n + 1));
  endfunction

endpackage

// File: rtl/hamming_chunk_buffer.sv
// Shift register plus holding register feeding the serial stream LSB-first.
// A chunk goes straight into the shift register whenever that register empties on the same edge.
module hamming_chunk_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         accept,
  input  logic         shift,
  input  logic [W-1:0] in_data,
  output logic         head_bit,
  output logic         loaded,
  output logic         hold_full
);

  localparam int SW = $clog2(W + 1);

  logic [W-1:0]  sh;
  logic [W-1:0]  hold;
  logic [SW-1:0] sh_cnt;
  logic          sh_draining;

  assign head_bit    = sh[0];
  assign loaded      = (sh_cnt != '0);
  assign sh_draining = (sh_cnt == '0) || (shift && (sh_cnt == SW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      hold      <= '0;
      sh_cnt    <= '0;
      hold_full <= 1'b0;
    end else if (clear) begin
      sh_cnt    <= '0;
      hold_full <= 1'b0;
    end else if (sh_draining && hold_full) begin
      // Reload from the holding register; a same-edge accept refills it.
      sh        <= hold;
      sh_cnt    <= SW'(W);
      hold_full <= accept;
      if (accept) begin
        hold <= in_data;
      end
    end else if (sh_draining && accept) begin
      sh     <= in_data;
      sh_cnt <= SW'(W);
    end else begin
      if (shift) begin
        sh     <= sh >> 1;
        sh_cnt <= sh_cnt - 1'b1;
      end
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hamming_stream_tx.sv
// Chunked-to-serial transmitter: turns N/W chunks into an N-cycle framed bitstream
// for the serial Hamming-distance accumulator.
module hamming_stream_tx
  import hamming_stream_tx_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int CW = DEFAULT_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         bit_o,
  output logic         bit_valid,
  output logic         bit_first,
  output logic         bit_last,
  output logic         busy,
  output logic         done,
  output logic         underrun
);

  localparam int NUM_CHUNKS = N / W;
  localparam int CCW        = $clog2(NUM_CHUNKS + 1);

  if (!params_ok(N, W, CW)) begin : g_param_check
    $error("hamming_stream_tx: N must be a multiple of W and CW >= clog2(N+1)");
  end

  tx_state_e      state;
  tx_state_e      state_next;
  logic [CW-1:0]  bit_cnt;
  logic [CCW-1:0] chunk_cnt;
  logic           accept;
  logic           clear_buf;
  logic           head_bit;
  logic           loaded;
  logic           hold_full;

  hamming_chunk_buffer #(.W(W)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_buf),
    .accept    (accept),
    .shift     (bit_valid),
    .in_data   (in_data),
    .head_bit  (head_bit),
    .loaded    (loaded),
    .hold_full (hold_full)
  );

  assign accept    = in_valid && in_ready;
  assign bit_valid = (state == STREAM) && loaded;
  assign bit_o     = bit_valid && head_bit;
  assign bit_first = bit_valid && (bit_cnt == '0);
  assign bit_last  = bit_valid && (bit_cnt == CW'(N - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    clear_buf  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_buf  = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        in_ready = !hold_full && (chunk_cnt < CCW'(NUM_CHUNKS));
        if (bit_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A stall is any STREAM cycle with an empty shift register; bit_cnt holds across it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      chunk_cnt <= '0;
      underrun  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      bit_cnt   <= '0;
      chunk_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        chunk_cnt <= chunk_cnt + 1'b1;
      end
      if (bit_valid) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if ((state == STREAM) && !loaded) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_stream_tx.sv
// Self-checking bench for hamming_stream_tx: three instances (1600/32, 8/4, 1600/4) behind one driver.
module tb_hamming_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  int          sel;

  always #5 clk = ~clk;

  logic a_ready, a_bit, a_valid, a_first, a_last, a_busy, a_done, a_under;
  logic b_ready, b_bit, b_valid, b_first, b_last, b_busy, b_done, b_under;
  logic c_ready, c_bit, c_valid, c_first, c_last, c_busy, c_done, c_under;

  hamming_stream_tx #(.N(1600), .W(32), .CW(11)) dut_a (
    .clk(clk), .rst(rst), .start(start && (sel == 0)), .in_data(in_data),
    .in_valid(in_valid && (sel == 0)), .in_ready(a_ready), .bit_o(a_bit),
    .bit_valid(a_valid), .bit_first(a_first), .bit_last(a_last),
    .busy(a_busy), .done(a_done), .underrun(a_under));

  hamming_stream_tx #(.N(8), .W(4), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start && (sel == 1)), .in_data(in_data[3:0]),
    .in_valid(in_valid && (sel == 1)), .in_ready(b_ready), .bit_o(b_bit),
    .bit_valid(b_valid), .bit_first(b_first), .bit_last(b_last),
    .busy(b_busy), .done(b_done), .underrun(b_under));

  hamming_stream_tx #(.N(1600), .W(4), .CW(11)) dut_c (
    .clk(clk), .rst(rst), .start(start && (sel == 2)), .in_data(in_data[3:0]),
    .in_valid(in_valid && (sel == 2)), .in_ready(c_ready), .bit_o(c_bit),
    .bit_valid(c_valid), .bit_first(c_first), .bit_last(c_last),
    .busy(c_busy), .done(c_done), .underrun(c_under));

  logic [7:0] mon_a, mon_b, mon_c, mon;
  assign mon_a = {a_ready, a_bit, a_valid, a_first, a_last, a_busy, a_done, a_under};
  assign mon_b = {b_ready, b_bit, b_valid, b_first, b_last, b_busy, b_done, b_under};
  assign mon_c = {c_ready, c_bit, c_valid, c_first, c_last, c_busy, c_done, c_under};

  always_comb begin
    case (sel)
      0:       mon = mon_a;
      1:       mon = mon_b;
      default: mon = mon_c;
    endcase
  end

  logic m_ready, m_bit, m_valid, m_first, m_last, m_busy, m_done, m_under;
  assign {m_ready, m_bit, m_valid, m_first, m_last, m_busy, m_done, m_under} = mon;

  int checks;
  int errors;

  // Frame configuration and reference chunk list
  int          cfgN, cfgW, cfgRandValid, cfgStartAt, cfgResetAt;
  int          cfgStallIdx, cfgStallBits, cfgStallCycles;
  logic [31:0] chunks[$];

  // Observations from the last frame
  bit gotBits[$];
  int firstCount, firstPos, lastCount, lastPos, firstCyc, lastCyc;
  int doneCyc, doneCount, gaps, accepts, invalidNonzero;
  int underAtDone, underAfter, busyAfter, readyAt1;
  bit aborted, timedOut;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic fillChunks(input int mode);
    logic [31:0] v;
    chunks.delete();
    for (int i = 0; i < cfgN / cfgW; i++) begin
      v = (mode == 0) ? ((i << 8) | 32'h5A) : $urandom();
      if (cfgW < 32) v = v & ((32'd1 << cfgW) - 32'd1);
      chunks.push_back(v);
    end
  endtask

  // Runs one frame on the selected instance, recording the observed stream and events.
  task automatic applyStimulus();
    int cyc, idx, gapSeen;
    bit startPulsed, stallReleased, accepted, finished, doneSeen, allowed;
    gotBits.delete();
    firstCount = 0; firstPos = -1; lastCount = 0; lastPos = -1; firstCyc = -1; lastCyc = -1;
    doneCyc = -1; doneCount = 0; gaps = 0; accepts = 0; invalidNonzero = 0;
    underAtDone = -1; underAfter = -1; busyAfter = -1; readyAt1 = -1;
    aborted = 0; timedOut = 0;
    cyc = 0; idx = 0; gapSeen = 0;
    startPulsed = 0; stallReleased = 0; finished = 0; doneSeen = 0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    while (!finished) begin
      if (cyc > 0) start = 1'b0;
      if (cfgStartAt >= 0 && !startPulsed && gotBits.size() == cfgStartAt) begin
        start = 1'b1;
        startPulsed = 1;
      end
      if (cfgResetAt >= 0 && gotBits.size() == cfgResetAt) begin
        rst = 1'b1;
        #1;
        checkOutput("rst:outputsZero", int'(mon), 0);
        in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (!in_valid) begin
        allowed = !(idx == cfgStallIdx && !stallReleased);
        if (allowed && (cfgRandValid == 0 || $urandom_range(0, 1) == 1)) begin
          in_valid = 1'b1;
          in_data  = (idx < chunks.size()) ? chunks[idx] : 32'hFFFF_FFFF;
        end
      end

      @(negedge clk);
      if (cyc == 1) readyAt1 = m_ready;
      if (m_valid) begin
        if (gotBits.size() == 0) firstCyc = cyc;
        if (m_first) begin firstCount++; firstPos = gotBits.size(); end
        if (m_last) begin lastCount++; lastPos = gotBits.size(); end
        gotBits.push_back(m_bit);
        lastCyc = cyc;
      end else begin
        if (m_bit) invalidNonzero++;
        if (gotBits.size() > 0 && m_busy && !m_done) gaps++;
        if (cfgStallIdx >= 0 && !stallReleased && gotBits.size() >= cfgStallBits) begin
          gapSeen++;
          if (gapSeen >= cfgStallCycles - 1) stallReleased = 1;
        end
      end
      if (doneSeen) begin
        busyAfter = m_busy;
        underAfter = m_under;
        finished = 1;
      end
      if (m_done) begin
        doneCount++;
        doneCyc = cyc;
        underAtDone = m_under;
        doneSeen = 1;
      end
      accepted = in_valid && m_ready;
      if (accepted) accepts++;
      if (cyc > cfgN * 8 + 200) begin
        timedOut = 1;
        finished = 1;
      end

      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  // Compares the recorded stream against the chunk list: bit k is bit (k mod W) of chunk k/W.
  task automatic checkFrame(input string tag);
    int mism;
    int expBit;
    bit stalled;
    checkOutput({tag, ":timeout"}, int'(timedOut), 0);
    checkOutput({tag, ":bitCount"}, gotBits.size(), cfgN);
    mism = 0;
    for (int k = 0; k < gotBits.size() && k < cfgN; k++) begin
      expBit = int'((chunks[k / cfgW] >> (k % cfgW)) & 32'd1);
      if (int'(gotBits[k]) != expBit) mism++;
    end
    checkOutput({tag, ":dataMismatches"}, mism, 0);
    checkOutput({tag, ":firstCount"}, firstCount, 1);
    checkOutput({tag, ":firstPos"}, firstPos, 0);
    checkOutput({tag, ":lastCount"}, lastCount, 1);
    checkOutput({tag, ":lastPos"}, lastPos, cfgN - 1);
    checkOutput({tag, ":doneCount"}, doneCount, 1);
    checkOutput({tag, ":doneAfterLast"}, doneCyc, lastCyc + 1);
    checkOutput({tag, ":accepts"}, accepts, cfgN / cfgW);
    checkOutput({tag, ":bitWhileInvalid"}, invalidNonzero, 0);
    checkOutput({tag, ":busyAfterDone"}, busyAfter, 0);
    stalled = (gaps > 0);
    checkOutput({tag, ":underrunAtDone"}, underAtDone, int'(stalled));
    checkOutput({tag, ":underrunSticky"}, underAfter, int'(stalled));
  endtask

  initial begin
    int packed8;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sel = 0;
    cfgStartAt = -1; cfgResetAt = -1; cfgStallIdx = -1;
    cfgStallBits = 0; cfgStallCycles = 0; cfgRandValid = 0;
    #1;
    checkOutput("reset:outputsA", int'(mon_a), 0);
    checkOutput("reset:outputsB", int'(mon_b), 0);
    checkOutput("reset:outputsC", int'(mon_c), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Default geometry with continuous supply
    sel = 0; cfgN = 1600; cfgW = 32;
    fillChunks(0);
    applyStimulus();
    checkFrame("dflt");
    checkOutput("dflt:readyAt1", readyAt1, 1);
    checkOutput("dflt:firstCyc", firstCyc, 2);
    checkOutput("dflt:lastCyc", lastCyc, 1601);
    checkOutput("dflt:doneCyc", doneCyc, 1602);
    checkOutput("dflt:gaps", gaps, 0);

    // Small frame, fixed chunks 0xA then 0x3
    sel = 1; cfgN = 8; cfgW = 4;
    chunks.delete();
    chunks.push_back(32'hA);
    chunks.push_back(32'h3);
    applyStimulus();
    checkFrame("n8");
    packed8 = 0;
    for (int k = 0; k < gotBits.size() && k < 8; k++) packed8 |= int'(gotBits[k]) << k;
    checkOutput("n8:bitPattern", packed8, 'h3A);
    checkOutput("n8:firstCyc", firstCyc, 2);
    checkOutput("n8:lastCyc", lastCyc, 9);

    // Second chunk withheld for three cycles after the first chunk drains
    cfgStallIdx = 1; cfgStallBits = 4; cfgStallCycles = 3;
    applyStimulus();
    checkFrame("stall");
    checkOutput("stall:gaps", gaps, 3);
    checkOutput("stall:underrunAfter", underAfter, 1);
    cfgStallIdx = -1;

    // Next start clears the sticky underrun
    fillChunks(1);
    applyStimulus();
    checkFrame("n8clr");
    checkOutput("n8clr:underrunCleared", underAtDone, 0);

    // Start pulsed mid-frame is ignored
    sel = 0; cfgN = 1600; cfgW = 32;
    fillChunks(0);
    cfgStartAt = 5;
    applyStimulus();
    checkFrame("midStart");
    checkOutput("midStart:lastCyc", lastCyc, 1601);
    cfgStartAt = -1;

    // Reset at bit 700, then a fresh frame with random data and supply
    cfgResetAt = 700;
    fillChunks(1);
    applyStimulus();
    checkOutput("rst:aborted", int'(aborted), 1);
    checkOutput("rst:busyAfterRelease", int'(m_busy), 0);
    cfgResetAt = -1;
    cfgRandValid = 1;
    fillChunks(1);
    applyStimulus();
    checkFrame("afterRst");

    // Narrow chunks: reload every four bits, continuous then random supply
    sel = 2; cfgN = 1600; cfgW = 4; cfgRandValid = 0;
    fillChunks(1);
    applyStimulus();
    checkFrame("w4cont");
    checkOutput("w4cont:gaps", gaps, 0);
    checkOutput("w4cont:lastCyc", lastCyc, 1601);
    cfgRandValid = 1;
    fillChunks(1);
    applyStimulus();
    checkFrame("w4rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
